// File: rtl/bht_update_arb.sv
// BHT update scheduler: two resolution slots feed an in-order FIFO that drains one update per cycle.
// Optional same-cycle bypass when the queue is empty: define BHT_UPD_BYPASS_EN.
module bht_update_arb #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in0_valid,
    input  logic [PC_W-1:0]          in0_pc,
    input  logic                     in0_taken,
    output logic                     in0_ready,
    input  logic                     in1_valid,
    input  logic [PC_W-1:0]          in1_pc,
    input  logic                     in1_taken,
    output logic                     in1_ready,
    output logic                     update_valid,
    output logic [PC_W-1:0]          update_pc,
    output logic                     update_taken,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } upd_t;

    upd_t            mem [DEPTH];
    logic [AW-1:0]   head, tail, tail_nxt, wr1_idx;
    logic [CW-1:0]   cnt, cnt_nxt, free;
    logic            fire0, fire1, enq0, enq1, deq, byp0, byp1, empty;

    // Free space comes only from registered occupancy; a same-cycle dequeue earns no credit.
    assign free      = DEPTH_C - cnt;
    assign empty     = (cnt == '0);
    assign in0_ready = rst_n & ~flush & (free >= CW'(1));
    assign in1_ready = rst_n & ~flush & (in0_valid ? (free >= CW'(2)) : (free >= CW'(1)));
    assign fire0     = in0_valid & in0_ready;
    assign fire1     = in1_valid & in1_ready;
    assign deq       = ~empty & ~flush;

`ifdef BHT_UPD_BYPASS_EN
    // Oldest firing slot skips the empty queue; fire already excludes flush.
    assign byp0 = empty & fire0;
    assign byp1 = empty & ~fire0 & fire1;
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
`endif

    assign enq0     = fire0 & ~byp0;
    assign enq1     = fire1 & ~byp1;
    assign wr1_idx  = enq0 ? tail + AW'(1) : tail;
    assign tail_nxt = tail + AW'(enq0) + AW'(enq1);
    assign cnt_nxt  = cnt + CW'(enq0) + CW'(enq1) - CW'(deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + AW'(deq);
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Payload storage is never cleared; valid tracking lives entirely in head/tail/cnt.
    always_ff @(posedge clk) begin
        if (enq0) mem[tail]    <= '{pc: in0_pc, taken: in0_taken};
        if (enq1) mem[wr1_idx] <= '{pc: in1_pc, taken: in1_taken};
    end

    always_comb begin
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        if (deq) begin
            update_valid = 1'b1;
            update_pc    = mem[head].pc;
            update_taken = mem[head].taken;
        end else if (byp0) begin
            update_valid = 1'b1;
            update_pc    = in0_pc;
            update_taken = in0_taken;
        end else if (byp1) begin
            update_valid = 1'b1;
            update_pc    = in1_pc;
            update_taken = in1_taken;
        end
    end

    assign busy  = ~empty;
    assign count = cnt;
endmodule

// File: tb/tb_bht_update_arb.sv
// Directed bench for bht_update_arb in its default (no bypass) build, DEPTH=4.
module tb_bht_update_arb;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in0_valid = 1'b0, in0_taken = 1'b0, in1_valid = 1'b0, in1_taken = 1'b0;
    logic [PC_W-1:0] in0_pc = '0, in1_pc = '0;
    logic            in0_ready, in1_ready, update_valid, update_taken, busy;
    logic [PC_W-1:0] update_pc;
    logic [2:0]      count;

    int n_checks = 0;
    int n_pass   = 0;

    bht_update_arb #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_taken(in0_taken), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_taken(in1_taken), .in1_ready(in1_ready),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in1_valid = 1'b0; flush = 1'b0;
        in0_pc = '0; in1_pc = '0; in0_taken = 1'b0; in1_taken = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) $display("FAIL reset_ready_low: got %0b%0b want 00", in0_ready, in1_ready); else n_pass++;
        n_checks++; if (update_valid !== 1'b0) $display("FAIL reset_update_valid: got %0b want 0", update_valid); else n_pass++;
        next_cycle(); next_cycle();
        rst_n = 1'b1;
        next_cycle();
        n_checks++; if (update_valid !== 1'b0) $display("FAIL idle_update_valid: got %0b want 0", update_valid); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("FAIL idle_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b1) $display("FAIL idle_ready: got %0b%0b want 11", in0_ready, in1_ready); else n_pass++;
        n_checks++; if (update_pc !== '0 || update_taken !== 1'b0) $display("FAIL idle_update_data: got %h/%0b want 0/0", update_pc, update_taken); else n_pass++;
    endtask

    task automatic test_single();
        in0_valid = 1'b1; in0_pc = 32'h0000_1004; in0_taken = 1'b1;
        #1;
        n_checks++; if (update_valid !== 1'b0) $display("FAIL single_no_bypass: got %0b want 0", update_valid); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h1004 || update_taken !== 1'b1)
            $display("FAIL single_issue: got %0b %h %0b want 1 00001004 1", update_valid, update_pc, update_taken); else n_pass++;
        n_checks++; if (count !== 3'd1) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
        next_cycle();
        n_checks++; if (update_valid !== 1'b0 || update_pc !== '0) $display("FAIL single_after: got %0b %h want 0 0", update_valid, update_pc); else n_pass++;
        n_checks++; if (count !== 3'd0) $display("FAIL single_drained: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_dual();
        in0_valid = 1'b1; in0_pc = 32'h100; in0_taken = 1'b1;
        in1_valid = 1'b1; in1_pc = 32'h200; in1_taken = 1'b0;
        #1;
        n_checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b1) $display("FAIL dual_ready: got %0b%0b want 11", in0_ready, in1_ready); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h100 || update_taken !== 1'b1)
            $display("FAIL dual_first: got %0b %h %0b want 1 00000100 1", update_valid, update_pc, update_taken); else n_pass++;
        n_checks++; if (count !== 3'd2) $display("FAIL dual_count: got %0d want 2", count); else n_pass++;
        next_cycle();
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h200 || update_taken !== 1'b0)
            $display("FAIL dual_second: got %0b %h %0b want 1 00000200 0", update_valid, update_pc, update_taken); else n_pass++;
        next_cycle();
        n_checks++; if (update_valid !== 1'b0) $display("FAIL dual_done: got %0b want 0", update_valid); else n_pass++;
    endtask

    // Both slots offered every cycle; bench-side occupancy model predicts readies and acceptance.
    task automatic test_back_pressure();
        int mcount = 0, nin = 0, nout = 0, acc;
        logic exp_r0, exp_r1, saw_drop = 1'b0;
        logic [PC_W-1:0] base = 32'h4000_0000, pc0, pc1, exp_pc;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc < 40) begin
                pc0 = base + PC_W'(nin); pc1 = base + PC_W'(nin + 1);
                in0_valid = 1'b1; in0_pc = pc0; in0_taken = pc0[0];
                in1_valid = 1'b1; in1_pc = pc1; in1_taken = pc1[0];
            end else begin
                idle_inputs();
            end
            #1;
            exp_r0 = (mcount < DEPTH);
            exp_r1 = in0_valid ? (DEPTH - mcount >= 2) : (DEPTH - mcount >= 1);
            if (in0_valid && !exp_r1) saw_drop = 1'b1;
            n_checks++; if (count !== 3'(mcount)) $display("FAIL bp_count c%0d: got %0d want %0d", cyc, count, mcount); else n_pass++;
            n_checks++; if (in0_ready !== exp_r0 || in1_ready !== exp_r1)
                $display("FAIL bp_ready c%0d: got %0b%0b want %0b%0b", cyc, in0_ready, in1_ready, exp_r0, exp_r1); else n_pass++;
            if (mcount != 0) begin
                exp_pc = base + PC_W'(nout);
                n_checks++; if (update_valid !== 1'b1 || update_pc !== exp_pc || update_taken !== exp_pc[0])
                    $display("FAIL bp_order c%0d: got %0b %h %0b want 1 %h %0b", cyc, update_valid, update_pc, update_taken, exp_pc, exp_pc[0]); else n_pass++;
                nout++;
            end else begin
                n_checks++; if (update_valid !== 1'b0) $display("FAIL bp_idle c%0d: got %0b want 0", cyc, update_valid); else n_pass++;
            end
            acc = 0;
            if (in0_valid && exp_r0) acc++;
            if (in1_valid && exp_r1) acc++;
            nin += acc;
            mcount = mcount + acc - ((mcount != 0) ? 1 : 0);
            next_cycle();
        end
        n_checks++; if (nout !== nin) $display("FAIL bp_no_loss: got %0d issued want %0d accepted", nout, nin); else n_pass++;
        n_checks++; if (nin < 3 * DEPTH + 1) $display("FAIL bp_wraps: got %0d entries want >= %0d", nin, 3 * DEPTH + 1); else n_pass++;
        n_checks++; if (saw_drop !== 1'b1) $display("FAIL bp_in1_drop: got %0b want 1", saw_drop); else n_pass++;
    endtask

    task automatic test_flush();
        in0_valid = 1'b1; in0_pc = 32'hA0; in1_valid = 1'b1; in1_pc = 32'hA1;
        next_cycle();
        in0_pc = 32'hA2; in1_pc = 32'hA3;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", count); else n_pass++;
        flush = 1'b1; in0_valid = 1'b1; in0_pc = 32'hF00;
        #1;
        n_checks++; if (update_valid !== 1'b0 || update_pc !== '0) $display("FAIL flush_cycle_valid: got %0b %h want 0 0", update_valid, update_pc); else n_pass++;
        n_checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) $display("FAIL flush_cycle_ready: got %0b%0b want 00", in0_ready, in1_ready); else n_pass++;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd0 || busy !== 1'b0) $display("FAIL flush_cleared: got %0d/%0b want 0/0", count, busy); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (update_valid !== 1'b0) $display("FAIL flush_no_stale c%0d: got %h want none", i, update_pc); else n_pass++;
            next_cycle();
        end
        in0_valid = 1'b1; in0_pc = 32'h5000; in0_taken = 1'b0;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (update_valid !== 1'b1 || update_pc !== 32'h5000) $display("FAIL flush_resume: got %0b %h want 1 00005000", update_valid, update_pc); else n_pass++;
        next_cycle();
    endtask

    task automatic test_async_reset();
        in0_valid = 1'b1; in0_pc = 32'hB0; in0_taken = 1'b1;
        in1_valid = 1'b1; in1_pc = 32'hB1; in1_taken = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd2 || update_valid !== 1'b1) $display("FAIL arst_pre: got %0d/%0b want 2/1", count, update_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (update_valid !== 1'b0 || update_pc !== '0 || update_taken !== 1'b0)
            $display("FAIL arst_outputs: got %0b %h %0b want 0 0 0", update_valid, update_pc, update_taken); else n_pass++;
        n_checks++; if (count !== 3'd0 || busy !== 1'b0) $display("FAIL arst_count: got %0d/%0b want 0/0", count, busy); else n_pass++;
        n_checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) $display("FAIL arst_ready: got %0b%0b want 00", in0_ready, in1_ready); else n_pass++;
        next_cycle(); next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            n_checks++; if (update_valid !== 1'b0) $display("FAIL arst_no_stale c%0d: got %h want none", i, update_pc); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bht_update_arb.md
# bht_update_arb

Update scheduler for the branch history table. Collects resolved-branch outcomes from two branch-resolution slots, orders them (slot 0 before slot 1 within a cycle), buffers them in a small FIFO and issues at most one update per cycle on the BHT's single update port (`update_pc` / `update_taken` / `update_valid`). Sits between the execute/commit stage and the BHT and provides back-pressure to the resolution slots.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `PC_W`, 32: PC width.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear; discards all queued and incoming updates.
- `in0_valid`  in  1  slot 0 (older) has a resolved branch.
- `in0_pc`  in  PC_W  slot 0 branch PC.
- `in0_taken`  in  1  slot 0 actual outcome.
- `in0_ready`  out  1  slot 0 accepted when `in0_valid & in0_ready`.
- `in1_valid`, `in1_pc`, `in1_taken`, `in1_ready`: same as slot 0, for slot 1 (younger).
- `update_valid`  out  1  drives BHT `update_valid`.
- `update_pc`  out  PC_W  drives BHT `update_pc`.
- `update_taken`  out  1  drives BHT `update_taken`.
- `busy`  out  1  queue non-empty.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer: head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH. `count` is 0..DEPTH.
- `free = DEPTH - count`, from registered state only. Do not credit the same-cycle dequeue.
- `in0_ready = !flush & (free >= 1)`.
- `in1_ready = !flush & (in0_valid ? free >= 2 : free >= 1)`. This depends combinationally on `in0_valid` only, never on `in1_valid`.
- Enqueue order within a cycle: slot 0 at tail, then slot 1 at tail+1. If only slot 1 fires, it goes at tail.
- Slot 1 never bypasses an accepted slot 0, so program order is preserved.
- Dequeue: the BHT has no back-pressure. Whenever `count != 0 & !flush`, the head entry is presented, `update_valid = 1`, and head advances at the clock edge.
- Next `count = count + enq_n - deq_n`, where `enq_n` is 0..2 and `deq_n` is 0..1. A full queue with a simultaneous dequeue still reports `in0_ready = 0` that cycle; this is intended.
- Flush:
  - In the flush cycle, `update_valid = 0` and both readies are 0.
  - At the next edge, head, tail and count go to 0.
  - Stored data is not cleared.
- Reset mid-operation discards all queued updates immediately, with no drain.
- Reset values: `update_valid=0`, `update_pc=0`, `update_taken=0`, `busy=0`, `count=0`, head/tail=0.
- While `rst_n` is low, `in0_ready` and `in1_ready` are 0. With `count=0` and `flush=0` they read 1 after reset release.
- `update_pc` and `update_taken` are 0 whenever `update_valid=0`. Gate them in the output mux; never expose stale entries.

## Timing
- Without bypass: an update accepted at edge N is on `update_*` during cycle N+1 if the queue was empty.
- Otherwise it appears after all older entries drain, one per cycle.
- Peak sustained throughput is 1 update/cycle. Two inputs per cycle fill the queue at a net +1/cycle until ready drops.
- Ready is combinational from registers plus `in0_valid` and `flush`. The `update_*` outputs are combinational from registers (plus slot-0/slot-1 inputs when bypass is compiled in).

## Configuration
- `BHT_UPD_BYPASS_EN` defined:
  - When `count == 0` and `!flush`, the oldest firing input goes straight to `update_*` in the same cycle and is not enqueued. That is slot 0 if it fires, else slot 1.
  - If both slots fire, slot 0 bypasses and slot 1 is enqueued, appearing at N+1.
  - Latency is 0 cycles when the queue is empty.
- Undefined: no bypass path. All updates pass through the FIFO with 1-cycle minimum latency.

## Test plan
- Reset then idle, DEPTH=4 → `update_valid=0`, `count=0`, `in0_ready=in1_ready=1`.
- Single update: `in0` pc=0x0000_1004, taken=1 at cycle 1 → `update_valid=1`, pc=0x1004, taken=1 at cycle 2 (cycle 1 with `BHT_UPD_BYPASS_EN`), then `update_valid=0`.
- Dual update, queue empty:
  - Stimulus: `in0` pc=0x100, taken=1 and `in1` pc=0x200, taken=0 in the same cycle.
  - Required response: 0x100/1 then 0x200/0 on consecutive cycles, never swapped.
- Back-pressure:
  - Stimulus: both slots valid every cycle with incrementing PCs, DEPTH=4.
  - Required response: `in1_ready` drops when `free<2`. Order is preserved across all outputs, with no loss or duplication.
  - Wrap-around: the pointers wrap at least 3 times.
- Flush:
  - Stimulus: `flush` asserted while `count=3`, with `in0_valid` high.
  - Required response: in the flush cycle `update_valid=0` and `in0_ready=0`. The next cycle has `count=0`, `busy=0`, and none of the 3 queued entries is ever issued.
- Async reset: `rst_n` low mid-stream with `count=2` → outputs go to reset values immediately without a clock edge. After release, no stale update is issued.
